piso_serializer: RTL and testbench



---
 rtl/piso_serializer.sv | 181 ++++++++++++++++++
 tb/tb_piso_serializer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// ----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in / serial-out transmitter. A WIDTH-bit word is accepted over a
// valid/ready handshake and shifted out one bit per clock on a registered
// serial line. Frame markers let a downstream single-bit sampler align words.
//
// Parameters:
//   WIDTH      word length in bits (2..32)
//   MSB_FIRST  1 = bit WIDTH-1 goes out first, 0 = bit 0 goes out first
//
// Ports:
//   clk          system clock, all state changes on its rising edge
//   rst_n        asynchronous active-low reset
//   load_valid   upstream has a word available
//   load_data    word to transmit, captured only on a handshake edge
//   load_ready   serializer can accept a word this cycle
//   q            registered serial data bit (0 when idle)
//   q_valid      q carries a frame bit this cycle
//   frame_start  high during the first bit of each frame
//   done         high during the last bit of each frame
// ----------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             q,
    output logic             q_valid,
    output logic             frame_start,
    output logic             done
);

    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shiftNext;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_countNext;
    logic [CW-1:0]    w_countInc;
    logic             r_q;
    logic             w_qNext;
    logic             r_qValid;
    logic             w_qValidNext;
    logic             r_frameStart;
    logic             w_frameStartNext;
    logic             r_done;
    logic             w_doneNext;
    logic             r_armed;

    logic             w_handshake;
    logic             w_firstBit;
    logic [WIDTH-1:0] w_loadShift;
    logic             w_nextBit;
    logic [WIDTH-1:0] w_shiftAdvance;

    // The shift register always keeps the next bit to send at the output end
    // (MSB end for MSB-first, LSB end otherwise). On load the first bit goes
    // straight to q, so the register is preloaded already shifted by one.
    assign w_firstBit     = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
    assign w_loadShift    = MSB_FIRST ? (load_data << 1)   : (load_data >> 1);
    assign w_nextBit      = MSB_FIRST ? r_shift[WIDTH-1]   : r_shift[0];
    assign w_shiftAdvance = MSB_FIRST ? (r_shift << 1)     : (r_shift >> 1);

    assign w_countInc = r_count + CW'(1);

    // Ready is a pure decode of registered state. r_armed keeps it low until
    // the first edge after reset releases; accepting during the last bit
    // (r_done) is what gives gap-free back-to-back frames.
    assign load_ready  = r_armed && ((r_state == IDLE) || r_done);
    assign w_handshake = load_valid && load_ready;

    assign q           = r_q;
    assign q_valid     = r_qValid;
    assign frame_start = r_frameStart;
    assign done        = r_done;

    // Next-state and next-output logic. Every output is computed here and
    // registered, so nothing downstream sees a combinational path from the
    // upstream handshake. A handshake loads the first bit in the same edge,
    // either from IDLE or at the edge closing the last bit of a frame.
    always_comb begin
        w_stateNext      = r_state;
        w_shiftNext      = r_shift;
        w_countNext      = r_count;
        w_qNext          = r_q;
        w_qValidNext     = r_qValid;
        w_frameStartNext = r_frameStart;
        w_doneNext       = r_done;

        case (r_state)
            IDLE: begin
                if (w_handshake) begin
                    w_stateNext      = SHIFT;
                    w_shiftNext      = w_loadShift;
                    w_countNext      = '0;
                    w_qNext          = w_firstBit;
                    w_qValidNext     = 1'b1;
                    w_frameStartNext = 1'b1;
                    w_doneNext       = 1'b0;
                end
            end

            SHIFT: begin
                if (r_done) begin
                    if (w_handshake) begin
                        w_stateNext      = SHIFT;
                        w_shiftNext      = w_loadShift;
                        w_countNext      = '0;
                        w_qNext          = w_firstBit;
                        w_qValidNext     = 1'b1;
                        w_frameStartNext = 1'b1;
                        w_doneNext       = 1'b0;
                    end else begin
                        w_stateNext      = IDLE;
                        w_shiftNext      = '0;
                        w_countNext      = '0;
                        w_qNext          = 1'b0;
                        w_qValidNext     = 1'b0;
                        w_frameStartNext = 1'b0;
                        w_doneNext       = 1'b0;
                    end
                end else begin
                    w_shiftNext      = w_shiftAdvance;
                    w_countNext      = w_countInc;
                    w_qNext          = w_nextBit;
                    w_qValidNext     = 1'b1;
                    w_frameStartNext = 1'b0;
                    w_doneNext       = (w_countInc == LAST_IDX);
                end
            end

            default: begin
                w_stateNext      = IDLE;
                w_shiftNext      = '0;
                w_countNext      = '0;
                w_qNext          = 1'b0;
                w_qValidNext     = 1'b0;
                w_frameStartNext = 1'b0;
                w_doneNext       = 1'b0;
            end
        endcase
    end

    // State register. Reset clears everything, aborting any frame in flight;
    // the partial word is simply dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_count      <= '0;
            r_q          <= 1'b0;
            r_qValid     <= 1'b0;
            r_frameStart <= 1'b0;
            r_done       <= 1'b0;
            r_armed      <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_shift      <= w_shiftNext;
            r_count      <= w_countNext;
            r_q          <= w_qNext;
            r_qValid     <= w_qValidNext;
            r_frameStart <= w_frameStartNext;
            r_done       <= w_doneNext;
            r_armed      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// ----------------------------------------------------------------------------
// tb_piso_serializer
//
// Three serializer lanes share clock and reset:
//   lane 0: WIDTH=8, MSB first
//   lane 1: WIDTH=8, LSB first
//   lane 2: WIDTH=2, MSB first
// The driver pushes the expected bit stream of each accepted word into a
// per-lane queue; an independent monitor pops one entry per cycle and checks
// q/q_valid/frame_start/done/load_ready.
// ----------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int NI = 3;

    typedef struct packed {
        logic q;
        logic fs;
        logic dn;
    } bitRec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] inValid;
    logic [7:0] inData [NI];

    logic outReady0, outQ0, outQv0, outFs0, outDone0;
    logic outReady1, outQ1, outQv1, outFs1, outDone1;
    logic outReady2, outQ2, outQv2, outFs2, outDone2;

    logic [4:0] stat [NI];

    bitRec_t expQ [NI][$];

    int checkCount;
    int passCount;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .load_valid(inValid[0]), .load_data(inData[0]),
        .load_ready(outReady0), .q(outQ0), .q_valid(outQv0),
        .frame_start(outFs0), .done(outDone0)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .load_valid(inValid[1]), .load_data(inData[1]),
        .load_ready(outReady1), .q(outQ1), .q_valid(outQv1),
        .frame_start(outFs1), .done(outDone1)
    );

    piso_serializer #(.WIDTH(2), .MSB_FIRST(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .load_valid(inValid[2]), .load_data(inData[2][1:0]),
        .load_ready(outReady2), .q(outQ2), .q_valid(outQv2),
        .frame_start(outFs2), .done(outDone2)
    );

    // Status packed as {q_valid, q, frame_start, done, load_ready}
    assign stat[0] = {outQv0, outQ0, outFs0, outDone0, outReady0};
    assign stat[1] = {outQv1, outQ1, outFs1, outDone1, outReady1};
    assign stat[2] = {outQv2, outQ2, outFs2, outDone2, outReady2};

    function automatic int widthOf(input int k);
        return (k == 2) ? 2 : 8;
    endfunction

    function automatic bit msbOf(input int k);
        return (k != 1);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                      name, actual, expected, $time);
    endtask

    // Reference model: a word becomes WIDTH frame bits in transmit order,
    // first one marked frame_start, last one marked done.
    task automatic pushWord(input int k, input logic [7:0] w);
        int wd;
        int idx;
        bitRec_t r;
        wd = widthOf(k);
        for (int i = 0; i < wd; i++) begin
            idx  = msbOf(k) ? (wd - 1 - i) : i;
            r.q  = w[idx];
            r.fs = (i == 0);
            r.dn = (i == wd - 1);
            expQ[k].push_back(r);
        end
    endtask

    // Called between edges. Holds valid with the word until a ready edge,
    // records the word at that edge, and returns just after it with valid
    // still high so a following call continues back-to-back.
    task automatic applyStimulus(input int k, input logic [7:0] w);
        int waited;
        waited = 0;
        inValid[k] = 1'b1;
        inData[k]  = w;
        while (!stat[k][0] && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (waited >= 200) begin
            checkCount++;
            $display("[TB] FAIL lane%0d readyTimeout: load_ready stayed 0, expected 1", k);
        end else begin
            @(posedge clk);
            pushWord(k, w);
            #1;
        end
    endtask

    // Drop valid and scramble data; the DUT must ignore it.
    task automatic releaseLane(input int k);
        inValid[k] = 1'b0;
        inData[k]  = 8'($urandom);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: one queue entry per cycle while a frame is expected, else an
    // idle, ready line.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int k = 0; k < NI; k++) begin
                logic [4:0] e;
                bitRec_t    r;
                if (expQ[k].size() > 0) begin
                    r = expQ[k].pop_front();
                    e = {1'b1, r.q, r.fs, r.dn, r.dn};
                end else begin
                    e = 5'b00001;
                end
                checkOutput($sformatf("lane%0d status{qv,q,fs,done,rdy}", k),
                            32'(stat[k]), 32'(e));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int waited;
        int k;
        int burst;

        checkCount = 0;
        passCount  = 0;
        rst_n      = 1'b0;
        inValid    = '0;
        for (int i = 0; i < NI; i++) inData[i] = 8'h00;

        // Reset state
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++)
            checkOutput($sformatf("lane%0d resetState", i), 32'(stat[i]), 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        for (int i = 0; i < NI; i++)
            checkOutput($sformatf("lane%0d readyBeforeFirstEdge", i), 32'(stat[i]), 32'h0);
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++)
            checkOutput($sformatf("lane%0d readyAfterFirstEdge", i), 32'(stat[i]), 32'h1);

        $display("[TB] single words");
        applyStimulus(0, 8'hA5); releaseLane(0); waitCycles(10);
        applyStimulus(1, 8'hA5); releaseLane(1); waitCycles(10);
        applyStimulus(1, 8'h01); releaseLane(1); waitCycles(10);

        $display("[TB] back-to-back");
        applyStimulus(0, 8'hFF);
        applyStimulus(0, 8'h00);
        releaseLane(0);
        waitCycles(18);

        $display("[TB] backpressure");
        applyStimulus(0, 8'hC3);
        releaseLane(0);
        waitCycles(3);
        applyStimulus(0, 8'h3C);
        releaseLane(0);
        waitCycles(12);

        $display("[TB] reset mid-frame");
        applyStimulus(0, 8'h96);
        releaseLane(0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("lane%0d abortState", i), 32'(stat[i]), 32'h0);
            expQ[i].delete();
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        checkOutput("lane0 readyBeforeEdgeAfterAbort", 32'(stat[0]), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("lane0 readyAfterAbort", 32'(stat[0]), 32'h1);
        applyStimulus(0, 8'h5A); releaseLane(0); waitCycles(10);

        $display("[TB] WIDTH=2 back-to-back");
        applyStimulus(2, 8'h02);
        applyStimulus(2, 8'h01);
        releaseLane(2);
        waitCycles(6);

        $display("[TB] random traffic");
        for (int n = 0; n < 40; n++) begin
            k     = int'($urandom_range(0, NI - 1));
            burst = int'($urandom_range(1, 3));
            for (int b = 0; b < burst; b++) applyStimulus(k, 8'($urandom));
            releaseLane(k);
            waitCycles(int'($urandom_range(0, 4)));
        end

        waited = 0;
        while ((expQ[0].size() + expQ[1].size() + expQ[2].size()) > 0 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        if (waited >= 100) begin
            checkCount++;
            $display("[TB] FAIL drainTimeout: expected bits still queued after 100 cycles");
        end
        waitCycles(3);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
